ovc_ctrl: RTL and testbench

OVC_CTRL -- requirements
Module: ovc_ctrl

---
 rtl/ovc_ctrl_pkg.sv | 27 ++
 rtl/ovc_slot.sv | 96 +++++++++
 rtl/ovc_ctrl.sv | 86 ++++++++
 tb/tb_ovc_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ovc_ctrl_pkg.sv
// Shared definitions for the output-VC controller: VC, type, source and data
// widths, flit type codes and the per-VC lock state encoding.
// Width constants follow the "index of MSB" convention: a field declared with
// width W is logic [W:0].
package ovc_ctrl_pkg;

  localparam int unsigned VCH   = 3;  // number of VCs minus one
  localparam int unsigned VCHW  = 1;  // VC id MSB index
  localparam int unsigned TYPEW = 1;  // flit type MSB index
  localparam int unsigned DATAW = 31; // payload MSB index
  localparam int unsigned PORTW = 2;  // port id MSB index
  // Source id is port*NVC+vc, so it needs the port and VC fields side by side.
  localparam int unsigned SRCW  = PORTW + VCHW + 1;

  typedef enum logic [TYPEW:0] {
    FlitHead     = 2'b00,
    FlitBody     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } vc_state_e;

endpackage

// File: rtl/ovc_slot.sv
// One output VC: downstream credit counter plus packet-ownership lock FSM.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_fwd          a flit is forwarded to this VC this cycle
//   i_type, i_src  type and sending input VC of that flit
//   i_cred         downstream returns a credit for this VC this cycle
//   o_irdy         at least one credit available
//   o_ilck         VC owned by an in-flight packet
//   o_err          single-cycle protocol-violation indication
module ovc_slot
  import ovc_ctrl_pkg::*;
#(
  parameter int unsigned BUFDEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_fwd,
  input  logic [TYPEW:0] i_type,
  input  logic [SRCW:0]  i_src,
  input  logic           i_cred,
  output logic           o_irdy,
  output logic           o_ilck,
  output logic           o_err
);

  localparam int unsigned CNTW = $clog2(BUFDEPTH + 1);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  vc_state_e       r_state;
  vc_state_e       w_state_nxt;
  logic [SRCW:0]   r_owner;
  logic [SRCW:0]   w_owner_nxt;
  flit_type_e      w_type;

  assign w_type = flit_type_e'(i_type);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= CNTW'(BUFDEPTH);
      r_state <= StIdle;
      r_owner <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    o_err       = 1'b0;

    // A same-cycle forward and credit cancel out with no error check.
    if (i_fwd && !i_cred) begin
      if (r_cnt == '0) o_err = 1'b1;
      else             w_cnt_nxt = r_cnt - 1'b1;
    end else if (i_cred && !i_fwd) begin
      if (r_cnt == CNTW'(BUFDEPTH)) o_err = 1'b1;
      else                          w_cnt_nxt = r_cnt + 1'b1;
    end

    if (i_fwd) begin
      unique case (r_state)
        StIdle: begin
          case (w_type)
            FlitHead: begin
              w_state_nxt = StLocked;
              w_owner_nxt = i_src;
            end
            FlitHeadTail: ; // single-flit packet never takes the lock
            default: o_err = 1'b1;
          endcase
        end
        StLocked: begin
          if (i_src != r_owner) begin
            o_err = 1'b1;
          end else begin
            case (w_type)
              FlitTail: w_state_nxt = StIdle;
              FlitBody: ;
              default:  o_err = 1'b1;
            endcase
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign o_irdy = (r_cnt != '0);
  assign o_ilck = (r_state == StLocked);

endmodule

// File: rtl/ovc_ctrl.sv
// Output-VC controller for one physical router port: per-VC credit tracking
// and packet locking, a one-cycle output register toward the link, and a
// sticky protocol-error flag.
// Ports:
//   clk, rst_                       clock, synchronous active-high reset
//   fwd_valid/ovch/type/src/data    flit arriving from the crossbar
//   cred_valid, cred_vch            credit returned by the downstream router
//   irdy, ilck                      per-VC credit-available / locked flags
//   odata, osend, oovch             registered flit toward the link
//   err                             sticky protocol-violation flag
module ovc_ctrl
  import ovc_ctrl_pkg::*;
#(
  parameter int unsigned ROUTERID = 0,
  parameter int unsigned PCHID    = 0,
  parameter int unsigned BUFDEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           fwd_valid,
  input  logic [VCHW:0]  fwd_ovch,
  input  logic [TYPEW:0] fwd_type,
  input  logic [SRCW:0]  fwd_src,
  input  logic [DATAW:0] fwd_data,
  input  logic           cred_valid,
  input  logic [VCHW:0]  cred_vch,
  output logic [VCH:0]   irdy,
  output logic [VCH:0]   ilck,
  output logic [DATAW:0] odata,
  output logic           osend,
  output logic [VCHW:0]  oovch,
  output logic           err
);

  logic [DATAW:0] r_odata;
  logic           r_osend;
  logic [VCHW:0]  r_oovch;
  logic           r_err;
  logic [VCH:0]   w_slot_err;

  // Identification parameters are carried for error reporting by the
  // enclosing router; they do not affect this block's logic.
  logic w_unused_ids;
  assign w_unused_ids = ^{ROUTERID, PCHID};

  for (genvar v = 0; v <= VCH; v++) begin : g_slot
    logic w_fwd_hit;
    logic w_cred_hit;
    assign w_fwd_hit  = fwd_valid  && (fwd_ovch == (VCHW + 1)'(v));
    assign w_cred_hit = cred_valid && (cred_vch == (VCHW + 1)'(v));

    ovc_slot #(
      .BUFDEPTH (BUFDEPTH)
    ) u_slot (
      .i_clk  (clk),
      .i_rst  (rst_),
      .i_fwd  (w_fwd_hit),
      .i_type (fwd_type),
      .i_src  (fwd_src),
      .i_cred (w_cred_hit),
      .o_irdy (irdy[v]),
      .o_ilck (ilck[v]),
      .o_err  (w_slot_err[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_odata <= '0;
      r_osend <= 1'b0;
      r_oovch <= '0;
      r_err   <= 1'b0;
    end else begin
      r_odata <= fwd_data;
      r_osend <= fwd_valid;
      r_oovch <= fwd_ovch;
      r_err   <= r_err | (|w_slot_err);
    end
  end

  assign odata = r_odata;
  assign osend = r_osend;
  assign oovch = r_oovch;
  assign err   = r_err;

endmodule

// File: tb/tb_ovc_ctrl.sv
module tb_ovc_ctrl;
  import ovc_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           rst_;
  logic           fwd_valid;
  logic [VCHW:0]  fwd_ovch;
  logic [TYPEW:0] fwd_type;
  logic [SRCW:0]  fwd_src;
  logic [DATAW:0] fwd_data;
  logic           cred_valid;
  logic [VCHW:0]  cred_vch;
  logic [VCH:0]   irdy;
  logic [VCH:0]   ilck;
  logic [DATAW:0] odata;
  logic           osend;
  logic [VCHW:0]  oovch;
  logic           err;

  int n_pass  = 0;
  int n_total = 0;

  ovc_ctrl #(
    .ROUTERID (0),
    .PCHID    (0),
    .BUFDEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .fwd_valid  (fwd_valid),
    .fwd_ovch   (fwd_ovch),
    .fwd_type   (fwd_type),
    .fwd_src    (fwd_src),
    .fwd_data   (fwd_data),
    .cred_valid (cred_valid),
    .cred_vch   (cred_vch),
    .irdy       (irdy),
    .ilck       (ilck),
    .odata      (odata),
    .osend      (osend),
    .oovch      (oovch),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1ns afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fwd_valid  = 1'b0;
    fwd_ovch   = '0;
    fwd_type   = FlitBody;
    fwd_src    = '0;
    fwd_data   = '0;
    cred_valid = 1'b0;
    cred_vch   = '0;
  endtask

  task automatic set_fwd(input int vc, input flit_type_e t, input int src, input int data);
    fwd_valid = 1'b1;
    fwd_ovch  = (VCHW + 1)'(vc);
    fwd_type  = t;
    fwd_src   = (SRCW + 1)'(src);
    fwd_data  = (DATAW + 1)'(data);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (irdy !== 4'hF) $display("FAIL reset_irdy got %h want f", irdy); else n_pass++;
    n_total++; if (ilck !== 4'h0) $display("FAIL reset_ilck got %h want 0", ilck); else n_pass++;
    n_total++; if (osend !== 1'b0) $display("FAIL reset_osend got %b want 0", osend); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_total++; if (odata !== 32'h0) $display("FAIL reset_odata got %h want 0", odata); else n_pass++;
    n_total++; if (oovch !== 2'd0) $display("FAIL reset_oovch got %0d want 0", oovch); else n_pass++;
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_fwd(0, FlitHeadTail, 2, 32'hA000 + i);
      step();
      n_total++;
      if (odata !== 32'hA000 + i) $display("FAIL exh_odata%0d got %h want %h", i, odata, 32'hA000 + i);
      else n_pass++;
      if (i == 2) begin
        n_total++; if (irdy[0] !== 1'b1) $display("FAIL exh_irdy_3rd got %b want 1", irdy[0]); else n_pass++;
      end
    end
    idle_inputs();
    n_total++; if (irdy[0] !== 1'b0) $display("FAIL exh_irdy_4th got %b want 0", irdy[0]); else n_pass++;
    n_total++; if (ilck[0] !== 1'b0) $display("FAIL exh_headtail_nolock got %b want 0", ilck[0]); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL exh_err_early got %b want 0", err); else n_pass++;
    set_fwd(0, FlitHeadTail, 2, 32'hBEEF);
    step();
    idle_inputs();
    n_total++; if (err !== 1'b1) $display("FAIL exh_err_5th got %b want 1", err); else n_pass++;
    n_total++; if (dut.g_slot[0].u_slot.r_cnt !== 3'd0) $display("FAIL exh_cnt got %0d want 0", dut.g_slot[0].u_slot.r_cnt); else n_pass++;
    n_total++; if (osend !== 1'b1 || odata !== 32'hBEEF) $display("FAIL exh_flit_out got %b/%h want 1/beef", osend, odata); else n_pass++;
    step();
    n_total++; if (err !== 1'b1) $display("FAIL exh_err_sticky got %b want 1", err); else n_pass++;
    n_total++; if (osend !== 1'b0) $display("FAIL exh_osend_idle got %b want 0", osend); else n_pass++;
  endtask

  task automatic test_credit_overflow();
    do_reset();
    cred_valid = 1'b1;
    cred_vch   = 2'd2;
    step();
    idle_inputs();
    n_total++; if (err !== 1'b1) $display("FAIL ovf_err got %b want 1", err); else n_pass++;
    n_total++; if (dut.g_slot[2].u_slot.r_cnt !== 3'd4) $display("FAIL ovf_cnt got %0d want 4", dut.g_slot[2].u_slot.r_cnt); else n_pass++;
  endtask

  task automatic test_packet();
    do_reset();
    set_fwd(1, FlitHead, 3, 32'h11);
    step();
    n_total++; if (ilck[1] !== 1'b1) $display("FAIL pkt_lock_head got %b want 1", ilck[1]); else n_pass++;
    n_total++; if (oovch !== 2'd1) $display("FAIL pkt_oovch got %0d want 1", oovch); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      set_fwd(1, FlitBody, 3, 32'h12 + i);
      step();
      n_total++; if (ilck[1] !== 1'b1) $display("FAIL pkt_lock_body%0d got %b want 1", i, ilck[1]); else n_pass++;
    end
    set_fwd(1, FlitTail, 3, 32'h14);
    step();
    idle_inputs();
    n_total++; if (ilck[1] !== 1'b0) $display("FAIL pkt_unlock got %b want 0", ilck[1]); else n_pass++;
    n_total++; if (dut.g_slot[1].u_slot.r_cnt !== 3'd0) $display("FAIL pkt_cnt got %0d want 0", dut.g_slot[1].u_slot.r_cnt); else n_pass++;
    n_total++; if (irdy !== 4'b1101) $display("FAIL pkt_irdy got %b want 1101", irdy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL pkt_err got %b want 0", err); else n_pass++;
    cred_valid = 1'b1;
    cred_vch   = 2'd1;
    step();
    idle_inputs();
    n_total++; if (dut.g_slot[1].u_slot.r_cnt !== 3'd1 || irdy[1] !== 1'b1) $display("FAIL pkt_cred_ret got %0d/%b want 1/1", dut.g_slot[1].u_slot.r_cnt, irdy[1]); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_fwd(0, FlitHeadTail, 0, i);
      step();
    end
    set_fwd(0, FlitHeadTail, 0, 7);
    cred_valid = 1'b1;
    cred_vch   = 2'd0;
    step();
    idle_inputs();
    n_total++; if (dut.g_slot[0].u_slot.r_cnt !== 3'd2) $display("FAIL same_cnt got %0d want 2", dut.g_slot[0].u_slot.r_cnt); else n_pass++;
    n_total++; if (irdy[0] !== 1'b1) $display("FAIL same_irdy got %b want 1", irdy[0]); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL same_err got %b want 0", err); else n_pass++;
    // Forward and credit on different VCs each act independently.
    set_fwd(2, FlitHeadTail, 0, 8);
    cred_valid = 1'b1;
    cred_vch   = 2'd0;
    step();
    idle_inputs();
    n_total++; if (dut.g_slot[0].u_slot.r_cnt !== 3'd3) $display("FAIL split_cnt0 got %0d want 3", dut.g_slot[0].u_slot.r_cnt); else n_pass++;
    n_total++; if (dut.g_slot[2].u_slot.r_cnt !== 3'd3) $display("FAIL split_cnt2 got %0d want 3", dut.g_slot[2].u_slot.r_cnt); else n_pass++;
  endtask

  task automatic test_lock_errors();
    do_reset();
    set_fwd(1, FlitHead, 3, 1);
    step();
    set_fwd(1, FlitBody, 5, 2);
    step();
    idle_inputs();
    n_total++; if (err !== 1'b1) $display("FAIL foreign_err got %b want 1", err); else n_pass++;
    n_total++; if (ilck[1] !== 1'b1) $display("FAIL foreign_lock got %b want 1", ilck[1]); else n_pass++;
    n_total++; if (dut.g_slot[1].u_slot.r_owner !== 5'd3) $display("FAIL foreign_owner got %0d want 3", dut.g_slot[1].u_slot.r_owner); else n_pass++;
    // Foreign TAIL must not unlock either.
    set_fwd(1, FlitTail, 5, 3);
    step();
    idle_inputs();
    n_total++; if (ilck[1] !== 1'b1) $display("FAIL foreign_tail_lock got %b want 1", ilck[1]); else n_pass++;

    do_reset();
    set_fwd(1, FlitHead, 3, 1);
    step();
    set_fwd(1, FlitHead, 3, 2);
    step();
    idle_inputs();
    n_total++; if (err !== 1'b1 || ilck[1] !== 1'b1) $display("FAIL head_locked got %b/%b want 1/1", err, ilck[1]); else n_pass++;

    do_reset();
    set_fwd(2, FlitBody, 4, 1);
    step();
    idle_inputs();
    n_total++; if (err !== 1'b1 || ilck[2] !== 1'b0) $display("FAIL body_idle got %b/%b want 1/0", err, ilck[2]); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_fwd(1, FlitHead, 3, 1);
    step();
    set_fwd(1, FlitBody, 3, 2);
    step();
    step();
    idle_inputs();
    n_total++; if (dut.g_slot[1].u_slot.r_cnt !== 3'd1 || ilck[1] !== 1'b1) $display("FAIL mid_pre got %0d/%b want 1/1", dut.g_slot[1].u_slot.r_cnt, ilck[1]); else n_pass++;
    // Reset while a flit and a credit are both presented: neither may act.
    rst_ = 1'b1;
    set_fwd(1, FlitBody, 7, 3);
    cred_valid = 1'b1;
    cred_vch   = 2'd0;
    step();
    rst_ = 1'b0;
    idle_inputs();
    n_total++; if (ilck[1] !== 1'b0) $display("FAIL mid_ilck got %b want 0", ilck[1]); else n_pass++;
    n_total++; if (irdy[1] !== 1'b1) $display("FAIL mid_irdy got %b want 1", irdy[1]); else n_pass++;
    n_total++; if (dut.g_slot[1].u_slot.r_cnt !== 3'd4) $display("FAIL mid_cnt got %0d want 4", dut.g_slot[1].u_slot.r_cnt); else n_pass++;
    n_total++; if (err !== 1'b0 || osend !== 1'b0) $display("FAIL mid_err_osend got %b/%b want 0/0", err, osend); else n_pass++;
  endtask

  initial begin
    rst_ = 1'b1;
    idle_inputs();
    test_reset();
    test_credit_exhaust();
    test_credit_overflow();
    test_packet();
    test_same_cycle();
    test_lock_errors();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
